match_ctrl: RTL and testbench

Sequencing controller for a two-player paddle game. It owns the match state: the serve handshake with the ball engine, the point pause, the per-player score counters and win detection. It drives the `p1_score`, `p2_score` and `winner` inputs of the score display block. It sits between the game/ball engine, which reports points, and the HEX score display.

---
 rtl/match_pkg.sv | 20 ++
 rtl/match_ctrl_if.sv | 30 +++
 rtl/pause_timer.sv | 32 +++
 rtl/match_ctrl.sv | 101 ++++++++++
 tb/tb_match_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/match_pkg.sv
// match_pkg: shared state encoding, result/server codes and sizing helper for match_ctrl.
package match_pkg;

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, PAUSE, OVER} state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam logic SRV_P1 = 1'b0;
    localparam logic SRV_P2 = 1'b1;

    localparam int SCORE_W = 4;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// match_ctrl_if: game-side signals of match_ctrl.
//   master: controller side (drives serve_req, server, ball_reset, scores, winner, playing;
//           receives start, point_p1, point_p2, serve_ack).
//   slave : ball engine / display side, the mirror image.
interface match_ctrl_if;
    import match_pkg::*;

    logic               start;
    logic               point_p1;
    logic               point_p2;
    logic               serve_ack;
    logic               serve_req;
    logic               server;
    logic               ball_reset;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [1:0]         winner;
    logic               playing;

    modport master (
        input  start, point_p1, point_p2, serve_ack,
        output serve_req, server, ball_reset, p1_score, p2_score, winner, playing
    );

    modport slave (
        output start, point_p1, point_p2, serve_ack,
        input  serve_req, server, ball_reset, p1_score, p2_score, winner, playing
    );

endinterface

// File: rtl/pause_timer.sv
// pause_timer: load/decrement down-counter for the post-point pause.
//   clk, reset_n : clock, asynchronous active-low reset
//   load_i       : load PAUSE_CYCLES-1 (takes priority over decrement)
//   done_o       : counter is zero
module pause_timer
    import match_pkg::*;
#(
    parameter int PAUSE_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    output logic done_o
);

    localparam int W = cnt_width(PAUSE_CYCLES);
    localparam logic [W-1:0] LOAD = W'(PAUSE_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= LOAD;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: match sequencing FSM with serve handshake, point pause, scores and win detection.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : match_ctrl_if.master (start/point/serve_ack in; serve and score outputs out)
module match_ctrl
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          reset_n,
    match_ctrl_if.master  bus
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_t             state_q;
    logic [SCORE_W-1:0] p1_q, p2_q;
    logic [1:0]         winner_q;
    logic               server_q, serve_req_q, ball_reset_q, playing_q;

    logic [SCORE_W-1:0] p1_inc, p2_inc;
    logic               pt1, pt2, let_pt, p1_win, p2_win, new_match, load, done;

    assign pt1       = (state_q == PLAY) & bus.point_p1 & ~bus.point_p2;
    assign pt2       = (state_q == PLAY) & bus.point_p2 & ~bus.point_p1;
    assign let_pt    = (state_q == PLAY) & bus.point_p1 & bus.point_p2;
    // Saturating increments; the win check stops play before saturation can matter.
    assign p1_inc    = (p1_q == WIN) ? p1_q : p1_q + SCORE_W'(1);
    assign p2_inc    = (p2_q == WIN) ? p2_q : p2_q + SCORE_W'(1);
    assign p1_win    = pt1 & (p1_inc == WIN);
    assign p2_win    = pt2 & (p2_inc == WIN);
    assign new_match = ((state_q == IDLE) | (state_q == OVER)) & bus.start;
    assign load      = (pt1 & ~p1_win) | (pt2 & ~p2_win) | let_pt;

    pause_timer #(.PAUSE_CYCLES(PAUSE_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (load),
        .done_o  (done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            p1_q         <= '0;
            p2_q         <= '0;
            winner_q     <= WIN_NONE;
            server_q     <= SRV_P1;
            serve_req_q  <= 1'b0;
            ball_reset_q <= 1'b0;
            playing_q    <= 1'b0;
        end else begin
            ball_reset_q <= 1'b0;
            case (state_q)
                IDLE, OVER: if (new_match) begin
                    state_q      <= SERVE;
                    p1_q         <= '0;
                    p2_q         <= '0;
                    winner_q     <= WIN_NONE;
                    server_q     <= SRV_P1;
                    serve_req_q  <= 1'b1;
                    ball_reset_q <= 1'b1;
                end
                SERVE: if (bus.serve_ack) begin
                    state_q     <= PLAY;
                    serve_req_q <= 1'b0;
                    playing_q   <= 1'b1;
                end
                PLAY: if (pt1 | pt2 | let_pt) begin
                    playing_q <= 1'b0;
                    state_q   <= (p1_win | p2_win) ? OVER : PAUSE;
                    if (pt1) begin
                        p1_q     <= p1_inc;
                        server_q <= SRV_P2;
                    end
                    if (pt2) begin
                        p2_q     <= p2_inc;
                        server_q <= SRV_P1;
                    end
                    winner_q <= p1_win ? WIN_P1 : p2_win ? WIN_P2 : winner_q;
                end
                PAUSE: if (done) begin
                    state_q      <= SERVE;
                    serve_req_q  <= 1'b1;
                    ball_reset_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.serve_req  = serve_req_q;
    assign bus.server     = server_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.p1_score   = p1_q;
    assign bus.p2_score   = p2_q;
    assign bus.winner     = winner_q;
    assign bus.playing    = playing_q;

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed self-checking bench for match_ctrl with WIN_SCORE=3, PAUSE_CYCLES=4.
module tb_match_ctrl;
    import match_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    match_ctrl_if bus ();

    match_ctrl #(.WIN_SCORE(3), .PAUSE_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs all outputs: {state, serve_req, server, ball_reset, playing, winner, p1, p2}
    function automatic logic [31:0] outs();
        return {15'd0, dut.state_q, bus.serve_req, bus.server, bus.ball_reset,
                bus.playing, bus.winner, bus.p1_score, bus.p2_score};
    endfunction

    function automatic logic [31:0] mk(input state_t s, input logic rq, input logic sv,
                                       input logic br, input logic pl, input logic [1:0] w,
                                       input logic [3:0] a, input logic [3:0] b);
        return {15'd0, s, rq, sv, br, pl, w, a, b};
    endfunction

    // Counts PAUSE cycles (including the current one) until the state leaves PAUSE.
    task automatic count_pause(output int cnt);
        cnt = 0;
        while (dut.state_q == PAUSE && cnt < 20) begin
            cnt++;
            tick();
        end
    endtask

    task automatic pulse_ack();
        bus.serve_ack = 1'b1;
        tick();
        bus.serve_ack = 1'b0;
    endtask

    task automatic pulse_pt(input logic a, input logic b);
        bus.point_p1 = a;
        bus.point_p2 = b;
        tick();
        bus.point_p1 = 1'b0;
        bus.point_p2 = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.point_p1 = 1'b0;
        bus.point_p2 = 1'b0;
        bus.serve_ack = 1'b0;
        tick();
        tick();
        chk("reset_state", outs(), mk(IDLE, 0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        tick();
        pulse_pt(1, 0);
        chk("idle_point_ignored", outs(), mk(IDLE, 0, 0, 0, 0, 0, 0, 0));

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_serve", outs(), mk(SERVE, 1, 0, 1, 0, 0, 0, 0));
        tick();
        chk("ball_reset_one_cycle", outs(), mk(SERVE, 1, 0, 0, 0, 0, 0, 0));
        pulse_pt(1, 0);
        pulse_pt(0, 1);
        chk("serve_points_ignored", outs(), mk(SERVE, 1, 0, 0, 0, 0, 0, 0));

        pulse_ack();
        chk("ack_play", outs(), mk(PLAY, 0, 0, 0, 1, 0, 0, 0));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("play_start_ignored", outs(), mk(PLAY, 0, 0, 0, 1, 0, 0, 0));

        pulse_pt(1, 0);
        chk("p1_point", outs(), mk(PAUSE, 0, 1, 0, 0, 0, 1, 0));
        pulse_ack();
        chk("pause_ack_ignored", outs(), mk(PAUSE, 0, 1, 0, 0, 0, 1, 0));
        count_pause(n);
        chk("pause_len", n + 1, 4);
        chk("pause_to_serve", outs(), mk(SERVE, 1, 1, 1, 0, 0, 1, 0));

        pulse_ack();
        pulse_pt(1, 1);
        chk("let", outs(), mk(PAUSE, 0, 1, 0, 0, 0, 1, 0));
        count_pause(n);
        chk("let_pause_len", n, 4);
        chk("let_serve", outs(), mk(SERVE, 1, 1, 1, 0, 0, 1, 0));

        pulse_ack();
        pulse_pt(0, 1);
        chk("p2_pt1", outs(), mk(PAUSE, 0, 0, 0, 0, 0, 1, 1));
        count_pause(n);
        pulse_ack();
        pulse_pt(0, 1);
        chk("p2_pt2", outs(), mk(PAUSE, 0, 0, 0, 0, 0, 1, 2));
        count_pause(n);
        pulse_ack();
        pulse_pt(0, 1);
        chk("p2_wins", outs(), mk(OVER, 0, 0, 0, 0, 2, 1, 3));
        tick();
        chk("over_no_pause", outs(), mk(OVER, 0, 0, 0, 0, 2, 1, 3));
        pulse_pt(1, 0);
        pulse_pt(0, 1);
        pulse_ack();
        tick();
        chk("over_hold", outs(), mk(OVER, 0, 0, 0, 0, 2, 1, 3));

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart", outs(), mk(SERVE, 1, 0, 1, 0, 0, 0, 0));

        pulse_ack();
        pulse_pt(1, 0);
        count_pause(n);
        pulse_ack();
        pulse_pt(1, 0);
        count_pause(n);
        pulse_ack();
        pulse_pt(0, 1);
        tick();
        chk("mid_pause_setup", outs(), mk(PAUSE, 0, 0, 0, 0, 0, 2, 1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", outs(), mk(IDLE, 0, 0, 0, 0, 0, 0, 0));
        chk("async_reset_timer", 32'(dut.u_timer.cnt_q), 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle_after_reset", outs(), mk(IDLE, 0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("resume_start", outs(), mk(SERVE, 1, 0, 1, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
